// File: rtl/apb4_reg_slave.sv
// APB4 register slave: 16 x 32-bit registers in a 64-byte window.
// Registers 0..13 are read/write, 14 counts completed good transfers, 15 is a constant ID.
//
// state  | meaning
// IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
// ACCESS | request captured; wait states counting down, PREADY when zero
module apb4_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA4B5_0001
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERROR,
  output logic [31:0] REG0_OUT
);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [3:0]  strb_q, strb_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] regs_q [0:13];
  logic [31:0] regs_d [0:13];
  logic [31:0] cnt_q, cnt_d;

  logic [3:0]  idx;
  logic        in_window;
  logic        err;
  logic        ready;
  logic [31:0] rd_mux;

  // Decode of the captured request: register index, error conditions, read mux.
  always_comb begin
    idx       = addr_q[5:2];
    // Unsigned subtraction folds "below base" into a large offset.
    in_window = (addr_q - BASE_ADDR) < 32'd64;
    err       = !in_window || (addr_q[1:0] != 2'b00) || (write_q && (idx >= 4'd14));
    ready     = (state_q == ST_ACCESS) && (wait_q == 4'd0);
    rd_mux    = 32'd0;
    for (int k = 0; k < 14; k++) begin
      if (idx == 4'(k)) rd_mux = regs_q[k];
    end
    if (idx == 4'd14) rd_mux = cnt_q;
    if (idx == 4'd15) rd_mux = ID_VALUE;
  end

  assign PREADY    = ready;
  assign PSLVERROR = ready && err;
  assign PRDATA    = (ready && !write_q && !err) ? rd_mux : 32'd0;
  assign REG0_OUT  = regs_q[0];

  // Next-state: setup capture, wait countdown, abort, and completion side effects.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    strb_d  = strb_q;
    wait_d  = wait_q;
    regs_d  = regs_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // PENABLE already high here is a protocol violation and is ignored.
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wdata_d = PWDATA;
          write_d = PWRITE;
          strb_d  = PSTRB;
          wait_d  = 4'(WAIT_CYCLES);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          if (ready) begin
            state_d = ST_IDLE;
            if (!err) begin
              cnt_d = cnt_q + 32'd1;
              if (write_q) begin
                for (int k = 0; k < 14; k++) begin
                  if (idx == 4'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                      if (strb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                  end
                end
              end
            end
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register file flops with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      strb_q  <= 4'd0;
      wait_q  <= 4'd0;
      cnt_q   <= 32'd0;
      for (int k = 0; k < 14; k++) regs_q[k] <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      strb_q  <= strb_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < 14; k++) regs_q[k] <= regs_d[k];
    end
  end

endmodule

// File: tb/tb_apb4_reg_slave.sv
// Bench for apb4_reg_slave: three instances with 0, 2 and 3 wait states,
// a table of directed vectors, randomized transfers against a reference model,
// and hand sequences for abort, reset mid-transfer and counter wrap.
module tb_apb4_reg_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] ID   = 32'hA4B5_0001;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0;
  logic        penable = 1'b0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  psel = '0;

  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [31:0] reg0 [3];

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  apb4_reg_slave #(.BASE_ADDR(BASE), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_w0 (
    .HCLK(hclk), .HRESETn(hresetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel[0]), .PENABLE(penable), .PSTRB(pstrb), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERROR(pslverr[0]), .REG0_OUT(reg0[0]));

  apb4_reg_slave #(.BASE_ADDR(BASE), .WAIT_CYCLES(2), .ID_VALUE(ID)) u_w2 (
    .HCLK(hclk), .HRESETn(hresetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel[1]), .PENABLE(penable), .PSTRB(pstrb), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERROR(pslverr[1]), .REG0_OUT(reg0[1]));

  apb4_reg_slave #(.BASE_ADDR(BASE), .WAIT_CYCLES(3), .ID_VALUE(ID)) u_w3 (
    .HCLK(hclk), .HRESETn(hresetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel[2]), .PENABLE(penable), .PSTRB(pstrb), .PRDATA(prdata[2]),
    .PREADY(pready[2]), .PSLVERROR(pslverr[2]), .REG0_OUT(reg0[2]));

  // ---------------- reference model: plain register array per instance -----
  logic [31:0] m_regs [3][16];

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 16; k++) m_regs[d][k] = 32'd0;
  endfunction

  function automatic void model_xfer(input int d, input bit wr, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] st,
                                     output bit err, output logic [31:0] rd);
    int unsigned k;
    err = (a < BASE) || (a > BASE + 32'd63) || (a % 4 != 0);
    k = err ? 0 : (a - BASE) / 4;
    if (!err && wr && k >= 14) err = 1'b1;
    rd = 32'd0;
    if (!err) begin
      if (!wr) rd = (k == 15) ? ID : m_regs[d][k];
      else
        for (int b = 0; b < 4; b++)
          if (st[b]) m_regs[d][k][8*b +: 8] = wd[8*b +: 8];
      m_regs[d][14] = m_regs[d][14] + 32'd1;
    end
  endfunction

  // ---------------- helpers ------------------------------------------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One APB transfer on instance d; access-phase inputs are scrambled to show
  // they are ignored. cyc counts access cycles up to and including PREADY=1.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int cyc);
    @(negedge hclk);
    psel[d] = 1'b1; penable = 1'b0;
    paddr = a; pwdata = wd; pwrite = wr; pstrb = st;
    @(negedge hclk);
    penable = 1'b1;
    paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom); pstrb = 4'($urandom);
    cyc = 1;
    while (!pready[d] && cyc < 40) begin
      check32($sformatf("wait_err_low d%0d", d), {31'd0, pslverr[d]}, 32'd0);
      check32($sformatf("wait_rdata_zero d%0d", d), prdata[d], 32'd0);
      @(negedge hclk);
      cyc++;
    end
    if (!pready[d]) begin
      errors++;
      $display("FAIL timeout d%0d addr=%h actual=no_pready required=pready", d, a);
    end
    rd = prdata[d];
    err = pslverr[d];
    @(posedge hclk);
    #1;
    psel = '0; penable = 1'b0;
  endtask

  task automatic run_checked(input int d, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] st, input string tag);
    bit          e_err;
    logic [31:0] e_rd, rd;
    logic        err;
    int          cyc;
    model_xfer(d, wr, a, wd, st, e_err, e_rd);
    xfer(d, wr, a, wd, st, rd, err, cyc);
    check32({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    check32({tag, "_rdata"}, rd, e_rd);
    check32({tag, "_cycles"}, cyc, wait_of(d) + 1);
    #1;
    check32({tag, "_reg0"}, reg0[d], m_regs[d][0]);
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      check32($sformatf("%s_pready d%0d", tag, d), {31'd0, pready[d]}, 32'd0);
      check32($sformatf("%s_pslverr d%0d", tag, d), {31'd0, pslverr[d]}, 32'd0);
      check32($sformatf("%s_prdata d%0d", tag, d), prdata[d], 32'd0);
      check32($sformatf("%s_reg0 d%0d", tag, d), reg0[d], 32'd0);
    end
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    bit          e_err;
    logic [31:0] e_rd;
    logic [31:0] e_reg0;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input bit e_err, input logic [31:0] e_rd,
                              input logic [31:0] e_reg0);
    vec_t v;
    v.wr = wr; v.a = a; v.wd = wd; v.st = st; v.e_err = e_err; v.e_rd = e_rd; v.e_reg0 = e_reg0;
    tv.push_back(v);
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] rd;
    logic        err;
    int          cyc;
    bit          m_err;
    logic [31:0] m_rd;

    model_reset();
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check_all_zero("reset");
    hresetn = 1'b1;

    //      wr  addr            wdata          strb  err  rdata          reg0
    add(1, BASE + 32'h00, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         32'hDEAD_BEEF);
    add(0, BASE + 32'h00, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    add(0, BASE + 32'h38, 32'h0,         4'h0, 0, 32'd2,         32'hDEAD_BEEF);
    add(1, BASE + 32'h04, 32'h1111_1111, 4'hF, 0, 32'h0,         32'hDEAD_BEEF);
    add(1, BASE + 32'h04, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         32'hDEAD_BEEF);
    add(0, BASE + 32'h04, 32'h0,         4'h0, 0, 32'h11BB_11DD, 32'hDEAD_BEEF);
    add(1, BASE + 32'h40, 32'h0BAD_0BAD, 4'hF, 1, 32'h0,         32'hDEAD_BEEF);
    add(1, BASE + 32'h02, 32'h0BAD_0BAD, 4'hF, 1, 32'h0,         32'hDEAD_BEEF);
    add(1, BASE + 32'h38, 32'h0BAD_0BAD, 4'hF, 1, 32'h0,         32'hDEAD_BEEF);
    add(0, BASE + 32'h38, 32'h0,         4'h0, 0, 32'd6,         32'hDEAD_BEEF);
    add(0, BASE + 32'h00, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    add(0, BASE + 32'h04, 32'h0,         4'h0, 0, 32'h11BB_11DD, 32'hDEAD_BEEF);
    add(1, BASE + 32'h3C, 32'h0BAD_0BAD, 4'hF, 1, 32'h0,         32'hDEAD_BEEF);
    add(0, BASE + 32'h3C, 32'h0,         4'h0, 0, ID,            32'hDEAD_BEEF);
    add(1, BASE + 32'h00, 32'h1234_5678, 4'h0, 0, 32'h0,         32'hDEAD_BEEF);
    add(0, BASE + 32'h00, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    add(0, BASE + 32'h41, 32'h0,         4'h0, 1, 32'h0,         32'hDEAD_BEEF);
    add(0, BASE - 32'h04, 32'h0,         4'h0, 1, 32'h0,         32'hDEAD_BEEF);
    add(0, BASE + 32'h38, 32'h0,         4'h0, 0, 32'd12,        32'hDEAD_BEEF);

    for (int i = 0; i < tv.size(); i++) begin
      model_xfer(0, tv[i].wr, tv[i].a, tv[i].wd, tv[i].st, m_err, m_rd);
      xfer(0, tv[i].wr, tv[i].a, tv[i].wd, tv[i].st, rd, err, cyc);
      check32($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tv[i].e_err});
      check32($sformatf("vec%0d_rdata", i), rd, tv[i].e_rd);
      check32($sformatf("vec%0d_cycles", i), cyc, 1);
      #1;
      check32($sformatf("vec%0d_reg0", i), reg0[0], tv[i].e_reg0);
    end

    // Three wait states: ID read with PREADY on the fourth access cycle.
    model_xfer(2, 1'b0, BASE + 32'h3C, 32'h0, 4'h0, m_err, m_rd);
    xfer(2, 1'b0, BASE + 32'h3C, 32'h0, 4'h0, rd, err, cyc);
    check32("w3_id_cycles", cyc, 4);
    check32("w3_id_rdata", rd, ID);
    check32("w3_id_err", {31'd0, err}, 32'd0);

    // Randomized traffic on all three instances against the model.
    for (int i = 0; i < 150; i++) begin
      int          d;
      int unsigned sel;
      logic [31:0] a;
      d = int'($urandom_range(0, 2));
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = BASE + {26'd0, 4'($urandom), 2'b00};
      else if (sel == 8) a = BASE + {26'd0, 4'($urandom), 2'($urandom_range(1, 3))};
      else               a = ($urandom_range(0, 1) == 1) ? BASE + 32'd64 + 32'($urandom_range(0, 4095))
                                                         : BASE - 32'd4 - 32'($urandom_range(0, 4095));
      run_checked(d, 1'($urandom), a, $urandom, 4'($urandom), $sformatf("rnd%0d", i));
    end

    // Abort: PSEL dropped after one access cycle of a write (2 wait states).
    run_checked(1, 1'b1, BASE + 32'h0C, 32'h5555_AAAA, 4'hF, "abort_pre");
    @(negedge hclk);
    psel[1] = 1'b1; penable = 1'b0;
    paddr = BASE + 32'h0C; pwdata = 32'h1234_5678; pwrite = 1'b1; pstrb = 4'hF;
    @(negedge hclk);
    penable = 1'b1;
    check32("abort_wait_pready", {31'd0, pready[1]}, 32'd0);
    @(negedge hclk);
    psel = '0; penable = 1'b0;
    @(negedge hclk);
    check32("abort_idle_pready", {31'd0, pready[1]}, 32'd0);
    run_checked(1, 1'b0, BASE + 32'h0C, 32'h0, 4'h0, "abort_reg3");
    run_checked(1, 1'b0, BASE + 32'h38, 32'h0, 4'h0, "abort_reg14");

    // Reset asserted in the access phase of a write.
    @(negedge hclk);
    psel[1] = 1'b1; penable = 1'b0;
    paddr = BASE + 32'h00; pwdata = 32'hCAFE_F00D; pwrite = 1'b1; pstrb = 4'hF;
    @(negedge hclk);
    penable = 1'b1;
    hresetn = 1'b0;
    @(negedge hclk);
    check_all_zero("midreset");
    psel = '0; penable = 1'b0;
    hresetn = 1'b1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      run_checked(d, 1'b0, BASE + 32'h00, 32'h0, 4'h0, $sformatf("postrst_r0_d%0d", d));
      run_checked(d, 1'b0, BASE + 32'h0C, 32'h0, 4'h0, $sformatf("postrst_r3_d%0d", d));
      run_checked(d, 1'b0, BASE + 32'h38, 32'h0, 4'h0, $sformatf("postrst_r14_d%0d", d));
    end

    // Transfer counter wrap from all-ones.
    @(negedge hclk);
    force u_w0.cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_w0.cnt_q;
    m_regs[0][14] = 32'hFFFF_FFFF;
    xfer(0, 1'b0, BASE + 32'h38, 32'h0, 4'h0, rd, err, cyc);
    check32("wrap_pre_rdata", rd, 32'hFFFF_FFFF);
    model_xfer(0, 1'b0, BASE + 32'h38, 32'h0, 4'h0, m_err, m_rd);
    xfer(0, 1'b0, BASE + 32'h38, 32'h0, 4'h0, rd, err, cyc);
    check32("wrap_post_rdata", rd, 32'd0);
    model_xfer(0, 1'b0, BASE + 32'h38, 32'h0, 4'h0, m_err, m_rd);
    run_checked(0, 1'b0, BASE + 32'h38, 32'h0, 4'h0, "wrap_model");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_reg_slave.md
APB4_REG_SLAVE -- requirements
Module: apb4_reg_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000, base of a 64-byte register window.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, access-phase wait states inserted per transfer (legal range 0..15).
REQ-003 SHALL have parameter ID_VALUE, default 32'hA4B5_0001, constant returned by register 15.
REQ-004 HCLK  input  1  single clock; all state updates on rising edge.
REQ-005 HRESETn  input  1  reset, synchronous and active-low.
REQ-006 PADDR  input  32  APB byte address.
REQ-007 PWDATA  input  32  APB write data.
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PSEL  input  1  APB select.
REQ-010 PENABLE  input  1  APB access-phase indicator.
REQ-011 PSTRB  input  4  write byte strobes; PSTRB[n] enables PWDATA[8n+7:8n].
REQ-012 PRDATA  output  32  read data, valid while PREADY=1 on a read.
REQ-013 PREADY  output  1  transfer completion.
REQ-014 PSLVERROR  output  1  error response, valid only while PREADY=1.
REQ-015 REG0_OUT  output  32  current contents of register 0.

Function
REQ-016 SHALL implement 16 32-bit registers at BASE_ADDR + 4*k, k = PADDR[5:2]; registers 0..13 are read/write, 14 is read-only transfer counter, 15 is read-only ID_VALUE.
REQ-017 SHALL use FSM states IDLE and ACCESS.
REQ-018 IDLE: on PSEL=1 & PENABLE=0, capture PADDR, PWRITE, PWDATA, PSTRB, load wait counter = WAIT_CYCLES, go to ACCESS; PENABLE=1 with PSEL=1 in IDLE is a protocol violation, ignored, state stays IDLE.
REQ-019 ACCESS: PREADY = 1 combinationally iff state = ACCESS and wait counter = 0; otherwise wait counter decrements by 1 per cycle while PSEL=1 & PENABLE=1.
REQ-020 Transfer completes on the edge where PSEL=1 & PENABLE=1 & PREADY=1; FSM returns to IDLE; WAIT_CYCLES=0 gives the minimum 2-cycle (setup + access) transfer.
REQ-021 PSEL=0 while in ACCESS SHALL abort: return to IDLE next edge, no register write, no counter update.
REQ-022 Error (PSLVERROR=1 with PREADY) SHALL be flagged for: captured address outside [BASE_ADDR, BASE_ADDR+63]; captured PADDR[1:0] != 0; write to register 14 or 15.
REQ-023 Non-error write SHALL update only the bytes whose captured PSTRB bit is 1, at the completion edge; a write with PSTRB=0 completes with no change.
REQ-024 Errored writes SHALL modify no register; errored reads SHALL drive PRDATA = 0.
REQ-025 Non-error reads SHALL drive PRDATA = selected register contents; PRDATA = 0 whenever PREADY=0 or PWRITE captured = 1.
REQ-026 Register 14 SHALL increment by 1 on each completed non-error transfer (read or write), wrapping 32'hFFFF_FFFF -> 0.
REQ-027 PSLVERROR SHALL be 0 whenever PREADY=0.
REQ-028 Inputs sampled only in IDLE setup phase; changes to PADDR/PWDATA/PWRITE/PSTRB during ACCESS SHALL be ignored.

Reset
REQ-029 HRESETn=0 at a rising edge SHALL force state IDLE, wait counter 0, registers 0..14 to 0, PREADY=0, PSLVERROR=0, PRDATA=0, REG0_OUT=0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer with no register update; the first transfer after release behaves as from IDLE.

Verification
REQ-031 WAIT_CYCLES=0: write 32'hDEAD_BEEF to BASE_ADDR+0, PSTRB=4'hF -> PREADY=1 in 2nd cycle, PSLVERROR=0, REG0_OUT=32'hDEAD_BEEF; read back -> PRDATA=32'hDEAD_BEEF, reg14=2.
REQ-032 WAIT_CYCLES=3: read BASE_ADDR+0x3C -> PREADY low for 3 access cycles then high on 4th, PRDATA=32'hA4B5_0001.
REQ-033 Reg 1 = 32'h1111_1111, write 32'hAABB_CCDD with PSTRB=4'b0101 -> reg 1 = 32'h11BB_11DD.
REQ-034 Write to BASE_ADDR+0x40, BASE_ADDR+0x02, and BASE_ADDR+0x38 -> each PSLVERROR=1 with PREADY, no register change, reg14 unchanged.
REQ-035 WAIT_CYCLES=2, deassert PSEL after one access cycle on write -> FSM IDLE, target register unchanged; then assert HRESETn=0 mid-transfer -> all outputs and registers 0.
REQ-036 Preload reg14 via reset-then-force 32'hFFFF_FFFF, complete one read -> reg14 = 0.
